// File: rtl/dm_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dm_pkg;

    localparam int WORD_W    = 32;
    localparam int BE_W      = 4;
    localparam int DM_ADDR_W = 10;

    typedef enum logic [1:0] {
        DM_IDLE   = 2'd0,
        DM_WAIT   = 2'd1,
        DM_ACCESS = 2'd2,
        DM_RESP   = 2'd3
    } dm_state_e;

    function automatic logic [WORD_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Bytes with their enable set come from the new data, the rest from the old word.
    function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_word,
                                                   input logic [WORD_W-1:0] new_word,
                                                   input logic [BE_W-1:0]   be);
        logic [WORD_W-1:0] m;
        m = be_mask(be);
        return (old_word & ~m) | (new_word & m);
    endfunction

endpackage

// File: rtl/dm_array.sv
// Word-addressed storage with per-byte synchronous write and combinational read.
module dm_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready request, fixed wait states, held response.
// Wait states are built only when DM_WAITSTATE_EN is defined.
module dm_responder
    import dm_pkg::*;
#(
    parameter int          ADDR_W      = DM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [WORD_W-1:0] ReqWData,
    input  logic [BE_W-1:0]   ReqBE,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [WORD_W-1:0] RspRData,
    output logic              Busy
);

`ifdef DM_WAITSTATE_EN
    localparam int unsigned EFF_WAIT = WAIT_CYCLES;
    localparam int          CNT_W    = 4;
`else
    // WAIT_CYCLES is still accepted so both builds share one parameter list.
    localparam int unsigned EFF_WAIT = WAIT_CYCLES - WAIT_CYCLES;
`endif

    dm_state_e         state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
`ifdef DM_WAITSTATE_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    dm_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .be    (be_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        arr_we  = 1'b0;
`ifdef DM_WAITSTATE_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            DM_IDLE: begin
                if (ReqValid) begin
                    write_d = ReqWrite;
                    addr_d  = ReqAddr;
                    wdata_d = ReqWData;
                    be_d    = ReqBE;
                    if (EFF_WAIT == 0) begin
                        state_d = DM_ACCESS;
                    end
`ifdef DM_WAITSTATE_EN
                    else begin
                        state_d = DM_WAIT;
                        cnt_d   = CNT_W'(EFF_WAIT);
                    end
`endif
                end
            end
`ifdef DM_WAITSTATE_EN
            DM_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DM_ACCESS;
                end
            end
`endif
            DM_ACCESS: begin
                // A reset landing on this edge must leave the array untouched.
                arr_we  = write_q && !Reset;
                rdata_d = write_q ? be_merge(arr_rdata, wdata_q, be_q) : arr_rdata;
                state_d = DM_RESP;
            end
            DM_RESP: begin
                if (RspReady) begin
                    state_d = DM_IDLE;
                end
            end
            default: begin
                state_d = DM_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= DM_IDLE;
            rdata_q <= '0;
`ifdef DM_WAITSTATE_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifdef DM_WAITSTATE_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Request latches carry data only; they are qualified by the FSM state.
    always_ff @(posedge CLK) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    assign ReqReady = (state_q == DM_IDLE) && !Reset;
    assign RspValid = (state_q == DM_RESP);
    assign Busy     = (state_q != DM_IDLE);
    assign RspRData = rdata_q;

endmodule
